// File: rtl/game_round_controller.sv
// Round sequencer for a timed character-recognition game.
// Runs NUM_ROUNDS rounds of load -> answer window -> result display, then
// parks in DONE until a new start. Every output is a flop updated on clock_1Hz.
module game_round_controller #(
  parameter int unsigned ROUND_SECS  = 10,
  parameter int unsigned NUM_ROUNDS  = 10,
  parameter int unsigned RESULT_SECS = 2
) (
  input  logic       clock_1Hz,
  input  logic       reset,
  input  logic       start,
  input  logic       submit,
  input  logic       match,
  output logic       load_char,
  output logic [7:0] score,
  output logic [3:0] round_num,
  output logic [5:0] sec_left,
  output logic       led_ok,
  output logic       led_bad,
  output logic       game_over,
  output logic [2:0] state
);

  localparam int unsigned SCORE_W = 8;
  localparam int unsigned ROUND_W = 4;
  localparam int unsigned SEC_W   = 6;
  localparam int unsigned CNT_W   = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ANSWER = 3'd2,
    S_RESULT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t cur_state;
  state_t nxt_state;

  logic [CNT_W-1:0]   res_cnt;
  logic [CNT_W-1:0]   res_cnt_d;
  logic [SCORE_W-1:0] score_d;
  logic [ROUND_W-1:0] round_num_d;
  logic [SEC_W-1:0]   sec_left_d;
  logic               led_ok_d;
  logic               led_bad_d;
  logic               load_char_d;
  logic               game_over_d;

  logic timeout;
  logic result_done;
  logic last_round;

  assign timeout     = (sec_left <= SEC_W'(1));
  assign result_done = (res_cnt == '0);
  assign last_round  = (round_num == ROUND_W'(NUM_ROUNDS));

  assign state = cur_state;

  // State register
  always_ff @(posedge clock_1Hz) begin
    if (reset) begin
      cur_state <= S_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state logic
  always_comb begin
    nxt_state = S_IDLE;
    case (cur_state)
      S_IDLE:   nxt_state = start ? S_LOAD : S_IDLE;
      S_LOAD:   nxt_state = S_ANSWER;
      S_ANSWER: nxt_state = (submit || timeout) ? S_RESULT : S_ANSWER;
      S_RESULT: begin
        if (!result_done) begin
          nxt_state = S_RESULT;
        end else begin
          nxt_state = last_round ? S_DONE : S_LOAD;
        end
      end
      S_DONE:   nxt_state = start ? S_LOAD : S_DONE;
      default:  nxt_state = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, keyed on the transition taken
  always_comb begin
    score_d     = score;
    round_num_d = round_num;
    sec_left_d  = sec_left;
    led_ok_d    = led_ok;
    led_bad_d   = led_bad;
    res_cnt_d   = res_cnt;
    load_char_d = 1'b0;
    game_over_d = 1'b0;

    case (cur_state)
      S_ANSWER: begin
        if (submit) begin
          // submit wins over a simultaneous timeout; sec_left is left as is
          if (match) begin
            score_d  = (score == '1) ? score : score + SCORE_W'(1);
            led_ok_d = 1'b1;
          end else begin
            led_bad_d = 1'b1;
          end
          res_cnt_d = CNT_W'(RESULT_SECS - 1);
        end else if (timeout) begin
          sec_left_d = '0;
          led_bad_d  = 1'b1;
          res_cnt_d  = CNT_W'(RESULT_SECS - 1);
        end else begin
          sec_left_d = sec_left - SEC_W'(1);
        end
      end
      S_RESULT: begin
        if (!result_done) begin
          res_cnt_d = res_cnt - CNT_W'(1);
        end
      end
      S_DONE: begin
        if (start) begin
          score_d     = '0;
          round_num_d = '0;
        end
      end
      S_LOAD: begin
        res_cnt_d = '0;
      end
      default: begin
        // IDLE and illegal encodings present an all-zero output set
        score_d     = '0;
        round_num_d = '0;
        sec_left_d  = '0;
        led_ok_d    = 1'b0;
        led_bad_d   = 1'b0;
        res_cnt_d   = '0;
      end
    endcase

    // Entering LOAD arms the next round
    if (nxt_state == S_LOAD) begin
      load_char_d = 1'b1;
      round_num_d = round_num_d + ROUND_W'(1);
      sec_left_d  = SEC_W'(ROUND_SECS);
      led_ok_d    = 1'b0;
      led_bad_d   = 1'b0;
    end

    game_over_d = (nxt_state == S_DONE);
  end

  // Output and result-counter registers
  always_ff @(posedge clock_1Hz) begin
    if (reset) begin
      score     <= '0;
      round_num <= '0;
      sec_left  <= '0;
      led_ok    <= 1'b0;
      led_bad   <= 1'b0;
      load_char <= 1'b0;
      game_over <= 1'b0;
      res_cnt   <= '0;
    end else begin
      score     <= score_d;
      round_num <= round_num_d;
      sec_left  <= sec_left_d;
      led_ok    <= led_ok_d;
      led_bad   <= led_bad_d;
      load_char <= load_char_d;
      game_over <= game_over_d;
      res_cnt   <= res_cnt_d;
    end
  end

endmodule

// File: tb/tb_game_round_controller.sv
// Directed bench for game_round_controller with ROUND_SECS=4, NUM_ROUNDS=3,
// RESULT_SECS=2. Expected output sets are queued as each tick is driven and
// compared after the following rising edge.
module tb_game_round_controller;

  logic       clock_1Hz = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       submit = 1'b0;
  logic       match = 1'b0;
  logic       load_char;
  logic [7:0] score;
  logic [3:0] round_num;
  logic [5:0] sec_left;
  logic       led_ok;
  logic       led_bad;
  logic       game_over;
  logic [2:0] state;

  typedef struct packed {
    logic [2:0] st;
    logic       ld;
    logic [3:0] rn;
    logic [5:0] sl;
    logic [7:0] sc;
    logic       ok;
    logic       bad;
    logic       go;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  game_round_controller #(
    .ROUND_SECS (4),
    .NUM_ROUNDS (3),
    .RESULT_SECS(2)
  ) dut (
    .clock_1Hz(clock_1Hz),
    .reset    (reset),
    .start    (start),
    .submit   (submit),
    .match    (match),
    .load_char(load_char),
    .score    (score),
    .round_num(round_num),
    .sec_left (sec_left),
    .led_ok   (led_ok),
    .led_bad  (led_bad),
    .game_over(game_over),
    .state    (state)
  );

  always #5 clock_1Hz = ~clock_1Hz;

  // Drive one tick of inputs, queue the expected outputs, compare after the edge
  task automatic step(input string tag, input logic r, input logic s, input logic sb, input logic m,
                      input int st, input logic ld, input int rn, input int sl, input int sc,
                      input logic ok, input logic bad, input logic go);
    exp_t e;
    exp_t got;
    obs_t obs;
    @(negedge clock_1Hz);
    reset  = r;
    start  = s;
    submit = sb;
    match  = m;
    e.tag  = tag;
    e.v    = '{st: 3'(st), ld: ld, rn: 4'(rn), sl: 6'(sl), sc: 8'(sc), ok: ok, bad: bad, go: go};
    exp_q.push_back(e);
    @(posedge clock_1Hz);
    #1;
    obs = '{st: state, ld: load_char, rn: round_num, sl: sec_left, sc: score,
            ok: led_ok, bad: led_bad, go: game_over};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      got = exp_q.pop_front();
      assert (obs === got.v) else begin
        failures++;
        $error("FAIL %s observed st=%0d ld=%b rn=%0d sl=%0d sc=%0d ok=%b bad=%b go=%b expected st=%0d ld=%b rn=%0d sl=%0d sc=%0d ok=%b bad=%b go=%b",
               got.tag, obs.st, obs.ld, obs.rn, obs.sl, obs.sc, obs.ok, obs.bad, obs.go,
               got.v.st, got.v.ld, got.v.rn, got.v.sl, got.v.sc, got.v.ok, got.v.bad, got.v.go);
      end
    end
  endtask

  // Hard time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    //     tag             rst st  sb  m    st ld rn sl sc ok bad go
    step("reset_dom",      1, 1, 1, 1,   0, 0, 0, 0, 0, 0, 0, 0);
    step("idle",           0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    step("idle_match_ign", 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 0, 0);
    step("start_load",     0, 1, 0, 0,   1, 1, 1, 4, 0, 0, 0, 0);
    step("answer_entry",   0, 1, 0, 0,   2, 0, 1, 4, 0, 0, 0, 0);
    step("match_no_sub",   0, 1, 0, 1,   2, 0, 1, 3, 0, 0, 0, 0);
    step("r1_correct",     0, 0, 1, 1,   3, 0, 1, 3, 1, 1, 0, 0);
    step("r1_result_hold", 0, 1, 1, 0,   3, 0, 1, 3, 1, 1, 0, 0);
    step("r2_load",        0, 0, 0, 0,   1, 1, 2, 4, 1, 0, 0, 0);
    step("r2_sec4",        0, 0, 0, 0,   2, 0, 2, 4, 1, 0, 0, 0);
    step("r2_sec3",        0, 0, 0, 0,   2, 0, 2, 3, 1, 0, 0, 0);
    step("r2_sec2",        0, 0, 0, 0,   2, 0, 2, 2, 1, 0, 0, 0);
    step("r2_sec1",        0, 0, 0, 0,   2, 0, 2, 1, 1, 0, 0, 0);
    step("r2_timeout",     0, 0, 0, 0,   3, 0, 2, 0, 1, 0, 1, 0);
    step("r2_result_hold", 0, 0, 0, 0,   3, 0, 2, 0, 1, 0, 1, 0);
    step("r3_load",        0, 0, 0, 0,   1, 1, 3, 4, 1, 0, 0, 0);
    step("r3_sec4",        0, 0, 0, 0,   2, 0, 3, 4, 1, 0, 0, 0);
    step("r3_sec3",        0, 0, 0, 0,   2, 0, 3, 3, 1, 0, 0, 0);
    step("r3_sec2",        0, 0, 0, 0,   2, 0, 3, 2, 1, 0, 0, 0);
    step("r3_sec1",        0, 0, 0, 0,   2, 0, 3, 1, 1, 0, 0, 0);
    step("r3_wrong_at_1",  0, 0, 1, 0,   3, 0, 3, 1, 1, 0, 1, 0);
    step("r3_result_hold", 0, 0, 0, 0,   3, 0, 3, 1, 1, 0, 1, 0);
    step("g1_done",        0, 0, 0, 0,   4, 0, 3, 1, 1, 0, 1, 1);
    step("g1_done_hold",   0, 0, 1, 1,   4, 0, 3, 1, 1, 0, 1, 1);
    step("g2_restart",     0, 1, 0, 0,   1, 1, 1, 4, 0, 0, 0, 0);
    step("g2_r1_answer",   0, 0, 0, 0,   2, 0, 1, 4, 0, 0, 0, 0);
    step("g2_r1_ok",       0, 0, 1, 1,   3, 0, 1, 4, 1, 1, 0, 0);
    step("g2_r1_hold",     0, 0, 0, 0,   3, 0, 1, 4, 1, 1, 0, 0);
    step("g2_r2_load",     0, 0, 0, 0,   1, 1, 2, 4, 1, 0, 0, 0);
    step("g2_r2_answer",   0, 0, 0, 0,   2, 0, 2, 4, 1, 0, 0, 0);
    step("g2_r2_ok",       0, 0, 1, 1,   3, 0, 2, 4, 2, 1, 0, 0);
    step("g2_r2_hold",     0, 0, 0, 0,   3, 0, 2, 4, 2, 1, 0, 0);
    step("g2_r3_load",     0, 0, 0, 0,   1, 1, 3, 4, 2, 0, 0, 0);
    step("g2_r3_answer",   0, 0, 0, 0,   2, 0, 3, 4, 2, 0, 0, 0);
    step("g2_r3_ok",       0, 0, 1, 1,   3, 0, 3, 4, 3, 1, 0, 0);
    step("g2_r3_hold",     0, 0, 0, 0,   3, 0, 3, 4, 3, 1, 0, 0);
    step("g2_done",        0, 0, 0, 0,   4, 0, 3, 4, 3, 1, 0, 1);
    step("g3_restart",     0, 1, 0, 0,   1, 1, 1, 4, 0, 0, 0, 0);
    step("g3_r1_answer",   0, 0, 0, 0,   2, 0, 1, 4, 0, 0, 0, 0);
    step("g3_r1_ok",       0, 0, 1, 1,   3, 0, 1, 4, 1, 1, 0, 0);
    step("g3_r1_hold",     0, 0, 0, 0,   3, 0, 1, 4, 1, 1, 0, 0);
    step("g3_r2_load",     0, 0, 0, 0,   1, 1, 2, 4, 1, 0, 0, 0);
    step("g3_r2_answer",   0, 0, 0, 0,   2, 0, 2, 4, 1, 0, 0, 0);
    step("g3_r2_ok",       0, 0, 1, 1,   3, 0, 2, 4, 2, 1, 0, 0);
    step("g3_r2_hold",     0, 0, 0, 0,   3, 0, 2, 4, 2, 1, 0, 0);
    step("g3_r3_load",     0, 0, 0, 0,   1, 1, 3, 4, 2, 0, 0, 0);
    step("g3_r3_answer",   0, 0, 0, 0,   2, 0, 3, 4, 2, 0, 0, 0);
    step("g3_r3_sec3",     0, 0, 0, 0,   2, 0, 3, 3, 2, 0, 0, 0);
    step("mid_reset",      1, 1, 1, 1,   0, 0, 0, 0, 0, 0, 0, 0);
    step("post_reset",     0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain leftover=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
